// File: rtl/dft_power_spectrum_if.sv
// Bin stream from the DFT core and power-spectrum result stream.
interface dft_power_spectrum_if #(
  parameter int N  = 18,
  parameter int W  = 48,
  parameter int BW = 12
);
  logic signed [N-1:0]  XK_RE;
  logic signed [N-1:0]  XK_IM;
  logic        [3:0]    BLK_EXP;
  logic                 FD_OUT;
  logic                 DATA_VALID;
  logic        [W-1:0]  PWR;
  logic        [BW-1:0] PWR_BIN;
  logic                 PWR_VALID;
  logic                 PWR_LAST;
  logic                 FRAME_ERR;

  // Source side: drives DFT bins, observes power results.
  modport master (
    output XK_RE, XK_IM, BLK_EXP, FD_OUT, DATA_VALID,
    input  PWR, PWR_BIN, PWR_VALID, PWR_LAST, FRAME_ERR
  );

  // Power-spectrum block side.
  modport slave (
    input  XK_RE, XK_IM, BLK_EXP, FD_OUT, DATA_VALID,
    output PWR, PWR_BIN, PWR_VALID, PWR_LAST, FRAME_ERR
  );
endinterface

// File: rtl/dft_power_spectrum.sv
// Per-bin power |Xk|^2 of a block-floating-point DFT stream, denormalised by
// the frame exponent and saturated to W bits. Tracks frame position (bin
// index) from the first-bin marker and flags frames that restart early.
module dft_power_spectrum #(
  parameter int N         = 18,
  parameter int W         = 48,
  parameter int FRAME_LEN = 48,
  parameter int BW        = 12
) (
  input  logic                 CLK,
  input  logic                 SCLR,
  dft_power_spectrum_if.slave  bus
);

  localparam int SW = 2 * N;
  // Wide enough for the largest shift (2*15) and always above bit W.
  localparam int XW = (SW + 30 > W) ? SW + 30 : W + 1;
  localparam logic [BW-1:0] LAST_BIN = BW'(FRAME_LEN - 1);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [BW-1:0] bin_q, bin_d;
  logic [3:0]    exp_q, exp_d;
  logic          accept, is_last, is_err;

  // Stage 1: registered inputs
  logic                 s1_v, s1_last, s1_err;
  logic signed [N-1:0]  s1_re, s1_im;
  logic        [BW-1:0] s1_bin;
  logic        [3:0]    s1_exp;

  // Stage 2: squares
  logic signed [SW-1:0] re_sq_c, im_sq_c;
  logic                 s2_v, s2_last, s2_err;
  logic        [SW-1:0] s2_re_sq, s2_im_sq;
  logic        [BW-1:0] s2_bin;
  logic        [3:0]    s2_exp;

  // Stage 3: sum, then shift/saturate into the output register
  logic                 s3_v, s3_last, s3_err;
  logic        [SW-1:0] s3_sum;
  logic        [BW-1:0] s3_bin;
  logic        [3:0]    s3_exp;
  logic        [XW-1:0] shifted_c;
  logic        [W-1:0]  pwr_c;

  // Control state register
  always_ff @(posedge CLK) begin
    if (SCLR) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state: enter RUN on any accepted sample, leave after the last bin
  always_comb begin
    state_d = state_q;
    if (accept) state_d = is_last ? IDLE : RUN;
  end

  // Acceptance, bin numbering and frame flags for the current input
  always_comb begin
    accept  = bus.DATA_VALID && (bus.FD_OUT || state_q == RUN);
    bin_d   = bus.FD_OUT ? '0 : bin_q + 1'b1;
    exp_d   = bus.FD_OUT ? bus.BLK_EXP : exp_q;
    is_last = accept && (bin_d == LAST_BIN);
    is_err  = accept && bus.FD_OUT && (state_q == RUN);
  end

  // Bin counter and latched frame exponent; gaps leave them untouched
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      bin_q <= '0;
      exp_q <= '0;
    end else if (accept) begin
      bin_q <= bin_d;
      exp_q <= exp_d;
    end
  end

  // Stage 1 register
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_err  <= 1'b0;
      s1_re   <= '0;
      s1_im   <= '0;
      s1_bin  <= '0;
      s1_exp  <= '0;
    end else begin
      s1_v    <= accept;
      s1_last <= is_last;
      s1_err  <= is_err;
      s1_re   <= bus.XK_RE;
      s1_im   <= bus.XK_IM;
      s1_bin  <= bin_d;
      s1_exp  <= exp_d;
    end
  end

  // Full-width signed squares; always non-negative and fit in 2N bits
  always_comb begin
    re_sq_c = s1_re * s1_re;
    im_sq_c = s1_im * s1_im;
  end

  // Stage 2 register
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      s2_v     <= 1'b0;
      s2_last  <= 1'b0;
      s2_err   <= 1'b0;
      s2_re_sq <= '0;
      s2_im_sq <= '0;
      s2_bin   <= '0;
      s2_exp   <= '0;
    end else begin
      s2_v     <= s1_v;
      s2_last  <= s1_last;
      s2_err   <= s1_err;
      s2_re_sq <= unsigned'(re_sq_c);
      s2_im_sq <= unsigned'(im_sq_c);
      s2_bin   <= s1_bin;
      s2_exp   <= s1_exp;
    end
  end

  // Stage 3 sum register; max sum is 2^(2N-1), so 2N bits never overflow
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      s3_v    <= 1'b0;
      s3_last <= 1'b0;
      s3_err  <= 1'b0;
      s3_sum  <= '0;
      s3_bin  <= '0;
      s3_exp  <= '0;
    end else begin
      s3_v    <= s2_v;
      s3_last <= s2_last;
      s3_err  <= s2_err;
      s3_sum  <= s2_re_sq + s2_im_sq;
      s3_bin  <= s2_bin;
      s3_exp  <= s2_exp;
    end
  end

  // Denormalise by 2*exponent and clamp anything reaching bit W
  always_comb begin
    shifted_c           = '0;
    shifted_c[SW-1:0]   = s3_sum;
    shifted_c           = shifted_c << {s3_exp, 1'b0};
    pwr_c               = (|shifted_c[XW-1:W]) ? '1 : shifted_c[W-1:0];
  end

  // Output register; fields are forced to zero when not valid.
  // The sum and the shift are split across two ranks so that results
  // appear three edges after the accepting edge.
  always_ff @(posedge CLK) begin
    if (SCLR || !s3_v) begin
      bus.PWR_VALID <= 1'b0;
      bus.PWR       <= '0;
      bus.PWR_BIN   <= '0;
      bus.PWR_LAST  <= 1'b0;
      bus.FRAME_ERR <= 1'b0;
    end else begin
      bus.PWR_VALID <= 1'b1;
      bus.PWR       <= pwr_c;
      bus.PWR_BIN   <= s3_bin;
      bus.PWR_LAST  <= s3_last;
      bus.FRAME_ERR <= s3_err;
    end
  end

endmodule

// File: tb/tb_dft_power_spectrum.sv
// Directed bench for dft_power_spectrum: each step drives one input vector
// with its hand-computed result, which is checked three edges later.
module tb_dft_power_spectrum;

  localparam int N  = 18;
  localparam int W  = 48;
  localparam int FL = 48;
  localparam int BW = 12;

  logic CLK = 1'b0;
  logic SCLR;

  always #5 CLK = ~CLK;

  dft_power_spectrum_if #(.N(N), .W(W), .BW(BW)) bus ();

  dft_power_spectrum #(.N(N), .W(W), .FRAME_LEN(FL), .BW(BW)) dut (
    .CLK  (CLK),
    .SCLR (SCLR),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected-result delay line: index 0 newest, index 3 due now
  logic          ev_v [4];
  logic [W-1:0]  ev_p [4];
  logic [BW-1:0] ev_b [4];
  logic          ev_l [4];
  logic          ev_e [4];

  task automatic cyc(input logic rst, input logic dv, input logic fd,
                     input int re, input int im, input int be,
                     input logic xv, input logic [W-1:0] xp, input int xb,
                     input logic xl, input logic xe, input string tag);
    logic [W+BW+2:0] obs, expv;
    SCLR           = rst;
    bus.DATA_VALID = dv;
    bus.FD_OUT     = fd;
    bus.XK_RE      = N'(re);
    bus.XK_IM      = N'(im);
    bus.BLK_EXP    = 4'(be);
    for (int i = 3; i > 0; i--) begin
      ev_v[i] = ev_v[i-1]; ev_p[i] = ev_p[i-1]; ev_b[i] = ev_b[i-1];
      ev_l[i] = ev_l[i-1]; ev_e[i] = ev_e[i-1];
    end
    ev_v[0] = xv;
    ev_p[0] = xv ? xp : '0;
    ev_b[0] = xv ? BW'(xb) : '0;
    ev_l[0] = xv ? xl : 1'b0;
    ev_e[0] = xv ? xe : 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        ev_v[i] = 1'b0; ev_p[i] = '0; ev_b[i] = '0; ev_l[i] = 1'b0; ev_e[i] = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
    obs  = {bus.PWR_VALID, bus.PWR, bus.PWR_BIN, bus.PWR_LAST, bus.FRAME_ERR};
    expv = {ev_v[3], ev_p[3], ev_b[3], ev_l[3], ev_e[3]};
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed v=%b pwr=%h bin=%0d last=%b err=%b, expected v=%b pwr=%h bin=%0d last=%b err=%b",
             tag, obs[W+BW+2], obs[W+BW+1:BW+2], obs[BW+1:2], obs[1], obs[0],
             expv[W+BW+2], expv[W+BW+1:BW+2], expv[BW+1:2], expv[1], expv[0]);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, '0, 0, 0, 0, tag);
  endtask

  task automatic reset_pulse(input int n);
    for (int k = 0; k < n; k++) cyc(1, 1, 1, 9, 9, 1, 0, '0, 0, 0, 0, "reset");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ev_v[i] = 1'b0; ev_p[i] = '0; ev_b[i] = '0; ev_l[i] = 1'b0; ev_e[i] = 1'b0;
    end
    SCLR = 1'b1;
    bus.DATA_VALID = 1'b0; bus.FD_OUT = 1'b0;
    bus.XK_RE = '0; bus.XK_IM = '0; bus.BLK_EXP = '0;

    // Reset state, then outputs stay clear right after release
    reset_pulse(2);
    idle(1, "post_reset");

    // Basic bin: 3^2 + 4^2 = 25
    cyc(0, 1, 1, 3, 4, 0, 1, 48'd25, 0, 0, 0, "basic");
    idle(3, "basic_tail");
    // FD without DATA_VALID ignored: next accepted sample continues as bin 1,
    // mid-frame exponent 9 ignored (latched 0): 1 + 1 = 2
    cyc(0, 0, 1, 7, 7, 0, 0, '0, 0, 0, 0, "fd_no_dv");
    cyc(0, 1, 0, 1, 1, 9, 1, 48'd2, 1, 0, 0, "bin1_after_fd_no_dv");
    idle(3, "fd_no_dv_tail");
    reset_pulse(1);

    // Exponent latch: 25 << 4 = 400, then 1 << 4 = 16 despite BLK_EXP=5
    cyc(0, 1, 1, 3, 4, 2, 1, 48'd400, 0, 0, 0, "exp_latch0");
    cyc(0, 1, 0, 1, 0, 5, 1, 48'd16, 1, 0, 0, "exp_latch1");
    idle(3, "exp_tail");
    reset_pulse(1);

    // Saturation: 2^35 << 30 saturates; 2^35 << 0; 2^35 << 12 = 2^47 fits;
    // 2^34 << 14 = 2^48 lands exactly at bit W and saturates
    cyc(0, 1, 1, -131072, -131072, 15, 1, 48'hFFFF_FFFF_FFFF, 0, 0, 0, "sat_max");
    cyc(0, 1, 1, -131072, -131072, 0,  1, 48'h0008_0000_0000, 0, 0, 1, "sat_exp0");
    cyc(0, 1, 1, -131072, -131072, 6,  1, 48'h8000_0000_0000, 0, 0, 1, "sat_below");
    cyc(0, 1, 1, -131072, 0,       7,  1, 48'hFFFF_FFFF_FFFF, 0, 0, 1, "sat_at_w");
    idle(3, "sat_tail");
    reset_pulse(1);

    // Frame A with random gaps: re=i, im=1 -> i*i+1, exponent 0 latched
    for (int i = 0; i < FL; i++) begin
      if (i > 0 && $urandom_range(0, 2) == 0) idle(1, "frame_gap");
      cyc(0, 1, (i == 0), i, 1, (i == 0) ? 0 : 3,
          1, W'(i * i + 1), i, (i == FL - 1), 0, "frameA_bin");
    end
    // After the last bin a non-FD sample is discarded
    cyc(0, 1, 0, 5, 5, 0, 0, '0, 0, 0, 0, "post_last_discard");

    // Frame B, no gaps, exponent 1: bin0 4<<2=16, others 2<<2=8
    for (int i = 0; i < FL; i++) begin
      cyc(0, 1, (i == 0), (i == 0) ? 2 : 1, (i == 0) ? 0 : 1, 1,
          1, (i == 0) ? W'(16) : W'(8), i, (i == FL - 1), 0, "frameB_bin");
    end
    // Frame C starts on the very next cycle: normal start, no error
    cyc(0, 1, 1, 0, 3, 0, 1, 48'd9, 0, 0, 0, "b2b_start");
    for (int i = 1; i < 10; i++)
      cyc(0, 1, 0, 1, 0, 0, 1, 48'd1, i, 0, 0, "frameC_bin");
    // Early restart where bin 10 would be
    cyc(0, 1, 1, 0, 5, 0, 1, 48'd25, 0, 0, 1, "early_restart");
    for (int i = 1; i < 20; i++)
      cyc(0, 1, 0, 1, 0, 0, 1, 48'd1, i, 0, 0, "after_restart_bin");

    // Reset with bins 17..19 in flight and bin 20 on the input
    cyc(1, 1, 0, 1, 0, 0, 0, '0, 0, 0, 0, "reset_mid_frame");
    for (int k = 0; k < 3; k++)
      cyc(0, 1, 0, 2, 2, 0, 0, '0, 0, 0, 0, "discard_after_reset");
    cyc(0, 1, 1, 1, 2, 1, 1, 48'd20, 0, 0, 0, "restart_after_reset");
    cyc(0, 1, 0, 0, 1, 0, 1, 48'd4, 1, 0, 0, "bin1_after_reset");
    idle(4, "final_tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
